// File: rtl/grid_pkg.sv
// grid_pkg: shared constants for the grid cursor painter slice.
//   GRID_COLS/GRID_ROWS : cell counts of the 6x4 template
//   rgb_t               : 12-bit {R,G,B} pixel
//   *_COLOR             : palette used by the pixel stage
package grid_pkg;
    localparam int GRID_COLS = 6;
    localparam int GRID_ROWS = 4;

    typedef logic [11:0] rgb_t;

    localparam rgb_t BG_COLOR     = 12'h222;
    localparam rgb_t LINE_COLOR   = 12'hFFF;
    localparam rgb_t CELL_COLOR   = 12'h008;
    localparam rgb_t CURSOR_COLOR = 12'hFF0;
    localparam rgb_t SEL_COLOR    = 12'h0F0;
endpackage

// File: rtl/grid_cursor_painter_btn_pulse.sv
// btn_pulse: 2-flop synchroniser followed by a rising-edge detector.
//   clk, rst_n : pixel clock, async active-low reset
//   level      : asynchronous debounced button level
//   pulse      : one-cycle pulse per rising edge of the synchronised level
// All flops reset to 0, so a button held across reset release reads as a
// fresh press.
module btn_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);
    logic sync1, sync2, prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= level;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;
endmodule

// File: rtl/grid_cursor_painter.sv
// grid_cursor_painter: pixel-colour stage behind the 6x4 grid template.
//   clk, rst_n              : pixel clock, async active-low reset
//   hc, vc                  : raster counters
//   matrix_x/matrix_y/lines : cell coordinates and grid-line flag from template
//   btn_*                   : debounced button levels (async to clk)
//   rgb                     : registered pixel, 1 cycle after hc/vc/matrix/lines
//   cursor_x/y              : cursor cell
//   sel_x/y, sel_valid      : selected cell
// Optional macro CURSOR_BLINK_EN: adds the frame counter that blinks the
// cursor every BLINK_FRAMES frames; without it the cursor is always drawn.
module grid_cursor_painter
    import grid_pkg::*;
#(
    parameter int GRID_XI      = 212,
    parameter int GRID_XF      = 812,
    parameter int GRID_YI      = 184,
    parameter int GRID_YF      = 584,
    parameter int H_VISIBLE    = 1024,
    parameter int V_VISIBLE    = 768,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hc,
    input  logic [10:0] vc,
    input  logic [2:0]  matrix_x,
    input  logic [1:0]  matrix_y,
    input  logic        lines,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_sel,
    output logic [11:0] rgb,
    output logic [2:0]  cursor_x,
    output logic [1:0]  cursor_y,
    output logic [2:0]  sel_x,
    output logic [1:0]  sel_y,
    output logic        sel_valid
);
    localparam logic [2:0] X_MAX = 3'(GRID_COLS - 1);
    localparam logic [1:0] Y_MAX = 2'(GRID_ROWS - 1);

    if (BLINK_FRAMES < 1 || BLINK_FRAMES > 63) begin : g_bad_blink
        $error("BLINK_FRAMES must be in 1..63");
    end

    // bit order: {sel, right, left, down, up}
    logic [4:0] btn_lvl, btn_pls;
    assign btn_lvl = {btn_sel, btn_right, btn_left, btn_down, btn_up};

    btn_pulse u_btn [4:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .level (btn_lvl),
        .pulse (btn_pls)
    );

    // One move per cycle (up > down > left > right); select is judged
    // against the cursor as it was before any move in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_x  <= '0;
            cursor_y  <= '0;
            sel_x     <= '0;
            sel_y     <= '0;
            sel_valid <= 1'b0;
        end else begin
            if (btn_pls[0])
                cursor_y <= (cursor_y == 2'd0) ? Y_MAX : cursor_y - 2'd1;
            else if (btn_pls[1])
                cursor_y <= (cursor_y == Y_MAX) ? 2'd0 : cursor_y + 2'd1;
            else if (btn_pls[2])
                cursor_x <= (cursor_x == 3'd0) ? X_MAX : cursor_x - 3'd1;
            else if (btn_pls[3])
                cursor_x <= (cursor_x == X_MAX) ? 3'd0 : cursor_x + 3'd1;

            if (btn_pls[4]) begin
                if (sel_valid && sel_x == cursor_x && sel_y == cursor_y) begin
                    sel_valid <= 1'b0;
                end else begin
                    sel_x     <= cursor_x;
                    sel_y     <= cursor_y;
                    sel_valid <= 1'b1;
                end
            end
        end
    end

`ifdef CURSOR_BLINK_EN
    logic       frame_tick;
    logic [5:0] frame_cnt;
    logic       blink_on;

    assign frame_tick = (hc == 11'd0) && (vc == 11'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_tick) begin
            if (frame_cnt == 6'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + 6'd1;
            end
        end
    end
`else
    logic blink_on;
    assign blink_on = 1'b1;
`endif

    logic visible, interior, on_cursor, on_sel;
    rgb_t pix_nxt;

    assign visible   = (hc < 11'(H_VISIBLE)) && (vc < 11'(V_VISIBLE));
    assign interior  = (hc > 11'(GRID_XI)) && (hc <= 11'(GRID_XF)) &&
                       (vc > 11'(GRID_YI)) && (vc <= 11'(GRID_YF));
    assign on_cursor = (matrix_x == cursor_x) && (matrix_y == cursor_y);
    assign on_sel    = sel_valid && (matrix_x == sel_x) && (matrix_y == sel_y);

    always_comb begin
        pix_nxt = CELL_COLOR;
        if (!visible)                  pix_nxt = 12'h000;
        else if (!interior)            pix_nxt = BG_COLOR;
        else if (lines)                pix_nxt = LINE_COLOR;
        else if (on_cursor && blink_on) pix_nxt = CURSOR_COLOR;
        else if (on_sel)               pix_nxt = SEL_COLOR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb <= '0;
        else        rgb <= pix_nxt;
    end
endmodule

// File: tb/tb_grid_cursor_painter.sv
// tb_grid_cursor_painter: directed self-checking bench for grid_cursor_painter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_grid_cursor_painter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hc = 11'd300, vc = 11'd300;
    logic [2:0]  matrix_x = '0;
    logic [1:0]  matrix_y = '0;
    logic        lines = 1'b0;
    logic        btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_sel = 0;
    logic [11:0] rgb;
    logic [2:0]  cursor_x, sel_x;
    logic [1:0]  cursor_y, sel_y;
    logic        sel_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    grid_cursor_painter #(.BLINK_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc),
        .matrix_x(matrix_x), .matrix_y(matrix_y), .lines(lines),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel),
        .rgb(rgb), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .sel_x(sel_x), .sel_y(sel_y), .sel_valid(sel_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    // id: 0 up, 1 down, 2 left, 3 right, 4 sel
    task automatic press(input int id);
        @(negedge clk);
        case (id)
            0: btn_up = 1;  1: btn_down = 1; 2: btn_left = 1;
            3: btn_right = 1; default: btn_sel = 1;
        endcase
        cyc(4);
        {btn_up, btn_down, btn_left, btn_right, btn_sel} = '0;
        cyc(4);
    endtask

    task automatic pix(input int h, input int v, input int mx, input int my,
                       input logic ln, input string tag, input logic [11:0] exp);
        @(negedge clk);
        hc = 11'(h); vc = 11'(v); matrix_x = 3'(mx); matrix_y = 2'(my); lines = ln;
        @(negedge clk);
        chk(tag, {20'd0, rgb}, {20'd0, exp});
    endtask

    task automatic tick();
        @(negedge clk);
        hc = 11'd0; vc = 11'd0;
        @(negedge clk);
        hc = 11'd300; vc = 11'd300;
    endtask

    initial begin
        // reset state
        cyc(1);
        chk("rst_rgb", {20'd0, rgb}, 32'h0);
        chk("rst_cur", {27'd0, cursor_x, cursor_y}, 32'h0);
        chk("rst_selv", {31'd0, sel_valid}, 32'h0);
        rst_n = 1'b1;
        pix(300, 300, 0, 0, 0, "cursor_pix", 12'hFF0);

        // wrap-around moves
        press(2);
        chk("left_wrap", {27'd0, cursor_x, cursor_y}, {27'd0, 3'd5, 2'd0});
        press(0);
        chk("up_wrap", {27'd0, cursor_x, cursor_y}, {27'd0, 3'd5, 2'd3});
        press(3);
        chk("right_wrap", {27'd0, cursor_x, cursor_y}, {27'd0, 3'd0, 2'd3});
        for (int i = 0; i < 5; i++) press(3);
        chk("six_right", {27'd0, cursor_x, cursor_y}, {27'd0, 3'd5, 2'd3});

        // to (2,1): right x3 -> (2,3), down -> (2,0) wrap, down -> (2,1)
        for (int i = 0; i < 3; i++) press(3);
        press(1);
        chk("down_wrap", {27'd0, cursor_x, cursor_y}, {27'd0, 3'd2, 2'd0});
        press(1);
        press(4);
        chk("sel_load", {26'd0, sel_valid, sel_x, sel_y}, {26'd0, 1'b1, 3'd2, 2'd1});
        press(4);
        chk("sel_clear", {31'd0, sel_valid}, 32'd0);
        press(3);
        press(4);
        chk("sel_move", {26'd0, sel_valid, sel_x, sel_y}, {26'd0, 1'b1, 3'd3, 2'd1});
        press(3); // cursor (4,1), sel stays (3,1)

        // pixel priority and boundaries
        pix(300, 300, 3, 1, 0, "sel_pix",    12'h0F0);
        pix(300, 300, 4, 1, 0, "cur_pix",    12'hFF0);
        pix(300, 300, 0, 0, 0, "cell_pix",   12'h008);
        pix(300, 300, 4, 1, 1, "line_pix",   12'hFFF);
        pix(100, 300, 0, 0, 0, "bg_pix",     12'h222);
        pix(1030, 300, 0, 0, 0, "hblank",    12'h000);
        pix(300, 800, 0, 0, 0, "vblank",     12'h000);
        pix(212, 300, 0, 0, 0, "xi_edge",    12'h222);
        pix(213, 300, 3, 1, 0, "xi_plus1",   12'h0F0);
        pix(812, 584, 3, 1, 0, "xf_yf",      12'h0F0);
        pix(300, 585, 3, 1, 0, "yf_plus1",   12'h222);
        pix(1023, 767, 0, 0, 0, "last_vis",  12'h222);

        // simultaneous up+left from (0,0); held for 100 cycles
        do_reset();
        @(negedge clk);
        btn_up = 1; btn_left = 1;
        cyc(100);
        chk("prio_hold", {27'd0, cursor_x, cursor_y}, {27'd0, 3'd0, 2'd3});
        btn_up = 0; btn_left = 0;
        cyc(4);

        // blink: two ticks turn the cursor off, two more turn it back on
        do_reset();
        matrix_x = '0; matrix_y = '0; lines = 0;
        tick(); tick();
        @(negedge clk);
`ifdef CURSOR_BLINK_EN
        chk("blink_off", {20'd0, rgb}, 32'h008);
`else
        chk("blink_off", {20'd0, rgb}, 32'hFF0);
`endif
        tick(); tick();
        @(negedge clk);
        chk("blink_on", {20'd0, rgb}, 32'hFF0);

        // mid-frame async reset
        press(3);
        press(4);
        chk("pre_rst", {26'd0, sel_valid, cursor_x, cursor_y}, {26'd0, 1'b1, 3'd1, 2'd0});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rgb", {20'd0, rgb}, 32'h0);
        chk("async_cur", {27'd0, cursor_x, cursor_y}, 32'h0);
        chk("async_sel", {26'd0, sel_valid, sel_x, sel_y}, 32'h0);

        // button held across reset release counts as one press
        btn_right = 1;
        cyc(2);
        rst_n = 1'b1;
        cyc(20);
        chk("held_rst", {27'd0, cursor_x, cursor_y}, {27'd0, 3'd1, 2'd0});
        btn_right = 0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/grid_cursor_painter.md
# grid_cursor_painter

Pixel-colour stage directly downstream of the 6x4 grid template. Consumes the raster counters plus the template's `matrix_x`/`matrix_y`/`lines` and produces the registered 12-bit RGB pixel. Maintains a button-driven cursor cell and one selected cell, and colours them distinctly. The output feeds the VGA output pins alongside hsync/vsync.

## Interface
- `GRID_XI`, 212: first-column boundary; the grid interior is `hc` in (GRID_XI, GRID_XF].
- `GRID_XF`, 812: last grid column.
- `GRID_YI`, 184: first-row boundary; the grid interior is `vc` in (GRID_YI, GRID_YF].
- `GRID_YF`, 584: last grid row.
- `H_VISIBLE`, 1024: visible width.
- `V_VISIBLE`, 768: visible height.
- `BLINK_FRAMES`, 30: frames per cursor blink half-period; range 1..63.
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `hc` in 11: horizontal counter.
- `vc` in 11: vertical counter.
- `matrix_x` in 3: cell column 0..5, from the template.
- `matrix_y` in 2: cell row 0..3, from the template.
- `lines` in 1: grid line flag, from the template.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_sel` in 1 each: debounced levels, asynchronous to `clk`.
- `rgb` out 12: pixel colour, {R[3:0], G[3:0], B[3:0]}.
- `cursor_x` out 3, `cursor_y` out 2: cursor cell.
- `sel_x` out 3, `sel_y` out 2, `sel_valid` out 1: selected cell.

## Operation
- Each button passes through a 2-flop synchroniser, then a rising-edge detector, producing a one-cycle pulse.
- Pulse priority when several occur in the same cycle: up > down > left > right. Only one move is applied; `sel` is evaluated independently in the same cycle against the pre-move cursor.
- Moves wrap around:
  - up: y 0→3
  - down: y 3→0
  - left: x 0→5
  - right: x 5→0
- Select:
  - If `sel_valid` and (sel_x, sel_y) equals the cursor, clear `sel_valid`.
  - Otherwise load sel = cursor and set `sel_valid`.
- Frame tick: `hc==0 && vc==0`.
- Blink: a 6-bit frame counter counts ticks; on reaching BLINK_FRAMES-1 it wraps to 0 and toggles `blink_on`.
- Pixel priority, evaluated on the current inputs:
  1. Outside visible area (`hc>=H_VISIBLE` or `vc>=V_VISIBLE`): 12'h000.
  2. Outside the grid interior: BG_COLOR.
  3. `lines`: LINE_COLOR.
  4. Cell == cursor and `blink_on`: CURSOR_COLOR.
  5. `sel_valid` and cell == sel: SEL_COLOR.
  6. Otherwise: CELL_COLOR.
- Cursor and selection coincide and `blink_on`=0: SEL_COLOR is shown.

## Timing
- Reset values:
  - `rgb` = 0
  - cursor = (0,0)
  - sel = (0,0), `sel_valid` = 0
  - `blink_on` = 1, frame counter = 0
  - synchroniser and edge flops = 0
- `rst_n` low at any time clears all state immediately. A button held high across reset release registers as one new press.
- `rgb` is registered: one cycle of latency from `hc`/`vc`/`matrix_*`/`lines`. Downstream delays hsync/vsync by one cycle to match.
- Button to cursor: a level first sampled high at clk edge N updates `cursor_*` at edge N+2 and holds there.
- A held button produces exactly one pulse. Release and re-press is needed for another.
- `cursor_*` and `sel_*` change mid-frame when they update; no frame-aligned shadowing is applied.
- Frame counter and `blink_on` update on the edge following the tick cycle.

## Configuration
- `CURSOR_BLINK_EN` defined: blink counter present, behaviour as above.
- `CURSOR_BLINK_EN` undefined: counter and `blink_on` removed, cursor always drawn (`blink_on` treated as constant 1). `BLINK_FRAMES` is ignored.

## Structure
- `grid_pkg` holds:
  - `GRID_COLS`=6, `GRID_ROWS`=4
  - typedef `rgb_t` (logic [11:0])
  - colour constants: BG_COLOR 12'h222, LINE_COLOR 12'hFFF, CELL_COLOR 12'h008, CURSOR_COLOR 12'hFF0, SEL_COLOR 12'h0F0
- One sub-module, `btn_pulse` (2-flop synchroniser plus edge detector, `clk`/`rst_n`, in level, out pulse), instantiated five times.

## Test plan
- Reset, then hc=300, vc=300, matrix=(0,0), lines=0 → after 1 cycle, `rgb`=12'hFF0; `cursor`=(0,0), `sel_valid`=0.
- Pulse `btn_left` once from (0,0) → cursor=(5,0). Pulse `btn_up` → (5,3). Six `btn_right` presses → back to (5,3).
- `btn_sel` at (2,1) → sel=(2,1), `sel_valid`=1. Second `btn_sel` → `sel_valid`=0. Move to (3,1) and select → sel=(3,1).
- `btn_up` and `btn_left` rising in the same cycle at (0,0) → cursor=(0,3) only. Holding both high for 100 cycles gives no further moves.
- Pixel input checks:
  - lines=1 inside grid → 12'hFFF.
  - hc=100 → 12'h222.
  - hc=1030 → 12'h000.
  - hc=300, vc=300 with cell==sel≠cursor → 12'h0F0.
- With `CURSOR_BLINK_EN` and BLINK_FRAMES=2: 2 frame ticks → cursor pixel shows CELL_COLOR 12'h008; 2 more ticks → 12'hFF0. Assert `rst_n` mid-frame → `rgb`=0 and state cleared immediately.
